// File: rtl/multi_threshold.sv
// Per-channel hysteresis onset detector with confirm count and optional onset timestamp capture.
// Timestamp timer/capture is built only when MULTI_THRESHOLD_TIMESTAMP_EN is defined.
module multi_threshold #(
  parameter int NCH     = 4,
  parameter int CW      = 32,
  parameter int CONFIRM = 2,
  parameter int TSW     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH*CW-1:0]   cntr,
  input  logic [NCH-1:0]      cntr_valid,
  input  logic [CW-1:0]       high,
  input  logic [CW-1:0]       low,
  input  logic                arm,
  output logic [NCH-1:0]      detect,
  output logic [NCH*TSW-1:0]  ts,
  output logic [NCH-1:0]      ts_valid,
  output logic                all_done
);

  typedef enum logic [1:0] {IDLE, PEND, ACTIVE} state_t;

  localparam logic [7:0] CONFIRM_C = 8'(CONFIRM);

  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [7:0]       ccnt_q  [NCH];
  logic [7:0]       ccnt_d  [NCH];
  logic [NCH-1:0]   detect_q, detect_d;
  logic [CW-1:0]    cntr_ch [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign cntr_ch[g] = cntr[g*CW +: CW];
  end

  // detect_d marks the qualifying sample; the pulse appears one edge later
  always_comb begin
    detect_d = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      ccnt_d[i]  = ccnt_q[i];
      if (cntr_valid[i]) begin
        case (state_q[i])
          IDLE, PEND: begin
            if (cntr_ch[i] >= high) begin
              if (ccnt_q[i] + 8'd1 == CONFIRM_C) begin
                state_d[i]  = ACTIVE;
                ccnt_d[i]   = '0;
                detect_d[i] = 1'b1;
              end else begin
                state_d[i] = PEND;
                ccnt_d[i]  = ccnt_q[i] + 8'd1;
              end
            end else begin
              state_d[i] = IDLE;
              ccnt_d[i]  = '0;
            end
          end
          ACTIVE: begin
            if (cntr_ch[i] <= low) state_d[i] = IDLE;
          end
          default: begin
            state_d[i] = IDLE;
            ccnt_d[i]  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        ccnt_q[i]  <= '0;
      end
      detect_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        ccnt_q[i]  <= ccnt_d[i];
      end
      detect_q <= detect_d;
    end
  end

  assign detect = detect_q;

`ifdef MULTI_THRESHOLD_TIMESTAMP_EN
  logic [TSW-1:0]     timer_q, timer_d;
  logic [NCH*TSW-1:0] ts_q, ts_d;
  logic [NCH-1:0]     ts_valid_q, ts_valid_d;
  logic               all_done_q, all_done_d;

  // Capture is applied after the arm clear so a same-cycle capture wins
  always_comb begin
    timer_d    = timer_q + TSW'(1);
    ts_d       = ts_q;
    ts_valid_d = arm ? '0 : ts_valid_q;
    for (int i = 0; i < NCH; i++) begin
      if (detect_d[i] && !ts_valid_q[i]) begin
        ts_d[i*TSW +: TSW] = timer_q;
        ts_valid_d[i]      = 1'b1;
      end
    end
    all_done_d = &ts_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q    <= '0;
      ts_q       <= '0;
      ts_valid_q <= '0;
      all_done_q <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      ts_q       <= ts_d;
      ts_valid_q <= ts_valid_d;
      all_done_q <= all_done_d;
    end
  end

  assign ts       = ts_q;
  assign ts_valid = ts_valid_q;
  assign all_done = all_done_q;
`else
  logic unused_arm;
  assign unused_arm = arm;
  assign ts         = '0;
  assign ts_valid   = '0;
  assign all_done   = 1'b0;
`endif

endmodule

// File: tb/tb_multi_threshold.sv
// Directed bench for multi_threshold: detection, hysteresis, reset and timestamp capture.
module tb_multi_threshold;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] cntr;
  logic [3:0]   cntr_valid;
  logic [31:0]  high, low;
  logic         arm;
  logic [3:0]   detect;
  logic [127:0] ts;
  logic [3:0]   ts_valid;
  logic         all_done;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] tmr;

  multi_threshold dut (
    .clk(clk), .rst(rst), .cntr(cntr), .cntr_valid(cntr_valid),
    .high(high), .low(low), .arm(arm), .detect(detect),
    .ts(ts), .ts_valid(ts_valid), .all_done(all_done)
  );

  always #5 clk = ~clk;

  // Reference timer: mirrors the value the design sees on the upcoming edge
  always @(posedge clk) tmr <= rst ? 32'd0 : tmr + 32'd1;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick(input logic [3:0] m, input logic [31:0] v);
    for (int i = 0; i < 4; i++) if (m[i]) cntr[i*32 +: 32] = v;
    cntr_valid = m;
    @(negedge clk);
  endtask

  task automatic td(input string tag, input logic [3:0] m, input logic [31:0] v, input logic [3:0] exp_det);
    tick(m, v);
    check(tag, {124'd0, detect}, {124'd0, exp_det});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cntr_valid = '0;
    @(negedge clk);
    check("rst_det", {124'd0, detect}, 128'd0);
    rst = 1'b0;
  endtask

  task automatic goto_time(input logic [31:0] t);
    int guard = 0;
    while (tmr != t && guard < 2000) begin
      cntr_valid = '0;
      @(negedge clk);
      guard++;
    end
    check("goto_time", {96'd0, tmr}, {96'd0, t});
  endtask

  task automatic chk_ts(input string tag, input logic [3:0] exp_v, input logic exp_all);
`ifdef MULTI_THRESHOLD_TIMESTAMP_EN
    check({tag, "_tsv"}, {124'd0, ts_valid}, {124'd0, exp_v});
    check({tag, "_all"}, {127'd0, all_done}, {127'd0, exp_all});
`else
    check({tag, "_tsv"}, {124'd0, ts_valid}, 128'd0);
    check({tag, "_all"}, {127'd0, all_done}, 128'd0);
    check({tag, "_ts"}, ts, 128'd0);
`endif
  endtask

  task automatic chk_ts_val(input string tag, input int ch, input logic [31:0] exp);
`ifdef MULTI_THRESHOLD_TIMESTAMP_EN
    check(tag, {96'd0, ts[ch*32 +: 32]}, {96'd0, exp});
`else
    check(tag, {96'd0, ts[ch*32 +: 32]}, 128'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; cntr = '0; cntr_valid = '0; arm = 1'b0;
    high = 32'd800; low = 32'd400;
    repeat (2) @(negedge clk);
    check("reset_ts", ts, 128'd0);
    chk_ts("reset", 4'b0000, 1'b0);
    do_reset();

    // Basic detect: pulse once, one cycle after the second 900
    td("basic_s1", 4'b0001, 900, 4'b0000);
    td("basic_s2", 4'b0001, 900, 4'b0001);
    td("basic_s3", 4'b0001, 900, 4'b0000);
    td("basic_s4", 4'b0001, 900, 4'b0000);
    td("to_idle1", 4'b0001, 300, 4'b0000);

    // Confirm broken by a sub-threshold sample
    td("brk_900a", 4'b0001, 900, 4'b0000);
    td("brk_700",  4'b0001, 700, 4'b0000);
    td("brk_900b", 4'b0001, 900, 4'b0000);
    td("brk_900c", 4'b0001, 900, 4'b0001);

    // Hysteresis: 401 keeps ACTIVE, 400 (inclusive) returns to IDLE
    td("hys_500",  4'b0001, 500, 4'b0000);
    td("hys_401",  4'b0001, 401, 4'b0000);
    td("hys_act1", 4'b0001, 900, 4'b0000);
    td("hys_act2", 4'b0001, 900, 4'b0000);
    td("hys_400",  4'b0001, 400, 4'b0000);
    td("hys_re1",  4'b0001, 900, 4'b0000);
    td("hys_re2",  4'b0001, 900, 4'b0001);
    td("to_idle2", 4'b0001, 300, 4'b0000);

    // Valid gaps hold the confirm count
    td("gap_900a", 4'b0001, 900, 4'b0000);
    for (int k = 0; k < 3; k++) td("gap_idle", 4'b0000, 0, 4'b0000);
    td("gap_900b", 4'b0001, 900, 4'b0001);
    td("to_idle3", 4'b0001, 300, 4'b0000);

    // Exactly high qualifies; other channels stay quiet
    td("eq_hi1", 4'b0010, 800, 4'b0000);
    td("eq_hi2", 4'b0010, 800, 4'b0010);
    td("to_idle4", 4'b0010, 300, 4'b0000);

    // Reset during PEND discards progress
    td("rp_900", 4'b0001, 900, 4'b0000);
    do_reset();
    td("rp_after", 4'b0001, 900, 4'b0000);
    td("rp_gap", 4'b0000, 0, 4'b0000);
    td("to_idle5", 4'b0001, 300, 4'b0000);

    // Reset during ACTIVE returns to IDLE
    td("ra_s1", 4'b0001, 900, 4'b0000);
    td("ra_s2", 4'b0001, 900, 4'b0001);
    do_reset();
    td("ra_s3", 4'b0001, 900, 4'b0000);
    td("ra_s4", 4'b0001, 900, 4'b0001);
    td("to_idle6", 4'b0001, 300, 4'b0000);

    // Timestamps
    do_reset();
    goto_time(99);
    td("t0_a", 4'b0001, 900, 4'b0000);
    td("t0_b", 4'b0001, 900, 4'b0001);
    chk_ts("t0", 4'b0001, 1'b0);
    chk_ts_val("t0_ts", 0, 100);
    td("t0_idle", 4'b0001, 300, 4'b0000);
    goto_time(249);
    td("t1_a", 4'b0010, 900, 4'b0000);
    td("t1_b", 4'b0010, 900, 4'b0010);
    chk_ts("t1", 4'b0011, 1'b0);
    goto_time(299);
    td("t23_a", 4'b1100, 900, 4'b0000);
    td("t23_b", 4'b1100, 900, 4'b1100);
    chk_ts("t23", 4'b1111, 1'b1);
    chk_ts_val("ts0", 0, 100);
    chk_ts_val("ts1", 1, 250);
    chk_ts_val("ts2", 2, 300);
    chk_ts_val("ts3", 3, 300);

    // A later detect must not overwrite a held timestamp
    td("ow_idle", 4'b0001, 300, 4'b0000);
    td("ow_a", 4'b0001, 900, 4'b0000);
    td("ow_b", 4'b0001, 900, 4'b0001);
    chk_ts_val("ow_ts0", 0, 100);

    // Arm clears valid flags, keeps values
    arm = 1'b1;
    td("arm", 4'b0000, 0, 4'b0000);
    arm = 1'b0;
    chk_ts("arm", 4'b0000, 1'b0);
    chk_ts_val("arm_ts0", 0, 100);
    td("arm_idle", 4'b0001, 300, 4'b0000);

    // Arm coincident with a capture: capture wins
    goto_time(499);
    td("ac_a", 4'b0001, 900, 4'b0000);
    arm = 1'b1;
    td("ac_b", 4'b0001, 900, 4'b0001);
    arm = 1'b0;
    chk_ts("ac", 4'b0001, 1'b0);
    chk_ts_val("ac_ts0", 0, 500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
